// File: rtl/spike_input_scheduler.sv
// Round-robin scheduler that funnels weighted spike events from NUM_SRC sources
// into a single registered neuron drive, with stall/drop blocking and saturating stats.
module spike_input_scheduler #(
    parameter int DATA_LENGTH = 32,
    parameter int NUM_SRC     = 4,
    parameter int BLOCK_MODE  = 0,
    parameter int CNT_WIDTH   = 16,
    localparam int IDW        = $clog2(NUM_SRC)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_SRC-1:0]             i_valid,
    input  logic [NUM_SRC*DATA_LENGTH-1:0] i_weight,
    output logic [NUM_SRC-1:0]             o_ready,
    input  logic                           i_block,
    input  logic                           i_clear_cnt,
    output logic [DATA_LENGTH-1:0]         o_spike_drive,
    output logic                           o_drive_valid,
    output logic [IDW-1:0]                 o_grant_id,
    output logic [CNT_WIDTH-1:0]           o_event_cnt,
    output logic [CNT_WIDTH-1:0]           o_drop_cnt
);

    localparam int CW = IDW + 1;
    localparam logic [CW-1:0]        NSRC    = CW'(NUM_SRC);
    localparam logic [IDW-1:0]       LAST    = IDW'(NUM_SRC - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [DATA_LENGTH-1:0] spikeDrive_q, spikeDrive_d;
    logic                   driveValid_q, driveValid_d;
    logic [IDW-1:0]         grantId_q, grantId_d;
    logic [CNT_WIDTH-1:0]   eventCnt_q, eventCnt_d;
    logic [CNT_WIDTH-1:0]   dropCnt_q, dropCnt_d;

    logic [CW-1:0]  cand;
    logic [IDW-1:0] grantIdx;
    logic           found;
    logic           allowGrant;
    logic           xfer;
    logic           deliver;
    logic           drop;

    // Wrapping search from the pointer; the first valid source wins.
    always_comb begin
        cand     = '0;
        grantIdx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= NSRC) begin
                cand = cand - NSRC;
            end
            if (!found && i_valid[cand[IDW-1:0]]) begin
                found    = 1'b1;
                grantIdx = cand[IDW-1:0];
            end
        end
    end

    assign allowGrant = !i_rst && !((BLOCK_MODE == 0) && i_block);
    assign xfer       = found && allowGrant;
    assign deliver    = xfer && !i_block;
    assign drop       = xfer && i_block;
    assign o_ready    = xfer ? (NUM_SRC'(1) << grantIdx) : '0;

    always_comb begin
        ptr_d        = ptr_q;
        spikeDrive_d = '0;
        driveValid_d = 1'b0;
        grantId_d    = grantId_q;
        eventCnt_d   = eventCnt_q;
        dropCnt_d    = dropCnt_q;
        if (xfer) begin
            ptr_d = (grantIdx == LAST) ? '0 : grantIdx + IDW'(1);
        end
        if (deliver) begin
            spikeDrive_d = i_weight[int'(grantIdx)*DATA_LENGTH +: DATA_LENGTH];
            driveValid_d = 1'b1;
            grantId_d    = grantIdx;
        end
        // Clear wins over a same-cycle increment.
        if (i_clear_cnt) begin
            eventCnt_d = '0;
            dropCnt_d  = '0;
        end else begin
            if (deliver && eventCnt_q != CNT_MAX) begin
                eventCnt_d = eventCnt_q + CNT_WIDTH'(1);
            end
            if (drop && dropCnt_q != CNT_MAX) begin
                dropCnt_d = dropCnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q        <= '0;
            spikeDrive_q <= '0;
            driveValid_q <= 1'b0;
            grantId_q    <= '0;
            eventCnt_q   <= '0;
            dropCnt_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            spikeDrive_q <= spikeDrive_d;
            driveValid_q <= driveValid_d;
            grantId_q    <= grantId_d;
            eventCnt_q   <= eventCnt_d;
            dropCnt_q    <= dropCnt_d;
        end
    end

    assign o_spike_drive = spikeDrive_q;
    assign o_drive_valid = driveValid_q;
    assign o_grant_id    = grantId_q;
    assign o_event_cnt   = eventCnt_q;
    assign o_drop_cnt    = dropCnt_q;

endmodule

// File: tb/tb_spike_input_scheduler.sv
// Directed bench: a stall-mode and a drop-mode scheduler (4 sources, 4-bit counters)
// share stimulus; each task checks the instance whose behaviour it exercises.
module tb_spike_input_scheduler;

    localparam int DL = 32;
    localparam int NS = 4;
    localparam int CWID = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     valid;
    logic [NS*DL-1:0]  weight;
    logic              block;
    logic              clearCnt;

    logic [NS-1:0]     readyS, readyD;
    logic [DL-1:0]     driveS, driveD;
    logic              driveValidS, driveValidD;
    logic [1:0]        grantIdS, grantIdD;
    logic [CWID-1:0]   eventCntS, eventCntD;
    logic [CWID-1:0]   dropCntS, dropCntD;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spike_input_scheduler #(.DATA_LENGTH(DL), .NUM_SRC(NS), .BLOCK_MODE(0), .CNT_WIDTH(CWID)) dutS (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_weight(weight), .o_ready(readyS),
        .i_block(block), .i_clear_cnt(clearCnt), .o_spike_drive(driveS),
        .o_drive_valid(driveValidS), .o_grant_id(grantIdS), .o_event_cnt(eventCntS),
        .o_drop_cnt(dropCntS)
    );

    spike_input_scheduler #(.DATA_LENGTH(DL), .NUM_SRC(NS), .BLOCK_MODE(1), .CNT_WIDTH(CWID)) dutD (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_weight(weight), .o_ready(readyD),
        .i_block(block), .i_clear_cnt(clearCnt), .o_spike_drive(driveD),
        .o_drive_valid(driveValidD), .o_grant_id(grantIdD), .o_event_cnt(eventCntD),
        .o_drop_cnt(dropCntD)
    );

    // Every drive/sample point sits 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; valid = '0; block = 1'b0; clearCnt = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        weight = {32'h40, 32'h30, 32'h20, 32'h10};
        rst = 1'b1; valid = 4'hF; block = 1'b0; clearCnt = 1'b0;
        step();
        step();
        checks++; if (readyS !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0000", readyS); end
        checks++; if (driveS !== 32'h0 || driveValidS !== 1'b0) begin failures++; $display("[TB] FAIL reset_drive got=%h/%b exp=0/0", driveS, driveValidS); end
        checks++; if (eventCntS !== 4'd0 || dropCntS !== 4'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", eventCntS, dropCntS); end
        rst = 1'b0;
        #1;
        checks++; if (readyS !== 4'b0001) begin failures++; $display("[TB] FAIL reset_first_grant got=%b exp=0001", readyS); end
        step();
        // Reset mid-flight: the event granted at the reset edge must vanish.
        rst = 1'b1;
        step();
        checks++; if (driveValidS !== 1'b0 || driveS !== 32'h0 || grantIdS !== 2'd0 || eventCntS !== 4'd0) begin
            failures++; $display("[TB] FAIL reset_midflight got=%b/%h/%0d/%0d exp=0/0/0/0", driveValidS, driveS, grantIdS, eventCntS);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] expId;
        logic [31:0] expW;
        doReset();
        weight = {32'h40, 32'h30, 32'h20, 32'h10};
        valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            expId = 2'(k % 4);
            expW  = 32'h10 * 32'(expId + 1);
            checks++; if (readyS !== (4'b0001 << expId)) begin failures++; $display("[TB] FAIL rr_ready%0d got=%b exp=%b", k, readyS, 4'b0001 << expId); end
            step();
            checks++; if (grantIdS !== expId || driveS !== expW || driveValidS !== 1'b1) begin
                failures++; $display("[TB] FAIL rr_drive%0d got=%0d/%h/%b exp=%0d/%h/1", k, grantIdS, driveS, driveValidS, expId, expW);
            end
        end
        checks++; if (eventCntS !== 4'd5) begin failures++; $display("[TB] FAIL rr_event_cnt got=%0d exp=5", eventCntS); end
        valid = 4'h0;
        step();
        checks++; if (driveS !== 32'h0 || driveValidS !== 1'b0 || grantIdS !== 2'd0) begin
            failures++; $display("[TB] FAIL rr_idle got=%h/%b/%0d exp=0/0/0", driveS, driveValidS, grantIdS);
        end
    endtask

    task automatic test_pointer_skip();
        doReset();
        weight = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        valid = 4'b1010;
        #1;
        checks++; if (readyS !== 4'b0010) begin failures++; $display("[TB] FAIL skip_ready1 got=%b exp=0010", readyS); end
        step();
        checks++; if (readyS !== 4'b1000) begin failures++; $display("[TB] FAIL skip_ready3 got=%b exp=1000", readyS); end
        step();
        checks++; if (grantIdS !== 2'd3 || driveS !== 32'hD4) begin failures++; $display("[TB] FAIL skip_grant3 got=%0d/%h exp=3/d4", grantIdS, driveS); end
        checks++; if (readyS !== 4'b0010) begin failures++; $display("[TB] FAIL skip_wrap got=%b exp=0010", readyS); end
        step();
        checks++; if (grantIdS !== 2'd1 || driveS !== 32'hB2) begin failures++; $display("[TB] FAIL skip_grant1 got=%0d/%h exp=1/b2", grantIdS, driveS); end
        valid = 4'b0000;
        step();
        checks++; if (driveS !== 32'h0 || driveValidS !== 1'b0 || grantIdS !== 2'd1) begin
            failures++; $display("[TB] FAIL skip_idle got=%h/%b/%0d exp=0/0/1", driveS, driveValidS, grantIdS);
        end
    endtask

    task automatic test_stall();
        doReset();
        weight = {32'h0, 32'h55, 32'h0, 32'h0};
        valid = 4'b0100;
        block = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (readyS !== 4'b0000) begin failures++; $display("[TB] FAIL stall_ready%0d got=%b exp=0000", k, readyS); end
            step();
            checks++; if (eventCntS !== 4'd0 || dropCntS !== 4'd0 || driveValidS !== 1'b0) begin
                failures++; $display("[TB] FAIL stall_idle%0d got=%0d/%0d/%b exp=0/0/0", k, eventCntS, dropCntS, driveValidS);
            end
        end
        block = 1'b0;
        #1;
        checks++; if (readyS !== 4'b0100) begin failures++; $display("[TB] FAIL stall_release got=%b exp=0100", readyS); end
        step();
        checks++; if (driveS !== 32'h55 || driveValidS !== 1'b1 || grantIdS !== 2'd2 || eventCntS !== 4'd1) begin
            failures++; $display("[TB] FAIL stall_deliver got=%h/%b/%0d/%0d exp=55/1/2/1", driveS, driveValidS, grantIdS, eventCntS);
        end
        valid = 4'b0000;
    endtask

    task automatic test_drop();
        doReset();
        weight = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        valid = 4'b0011;
        block = 1'b1;
        #1;
        checks++; if (readyD !== 4'b0001) begin failures++; $display("[TB] FAIL drop_ready0 got=%b exp=0001", readyD); end
        step();
        checks++; if (dropCntD !== 4'd1 || driveD !== 32'h0 || driveValidD !== 1'b0) begin
            failures++; $display("[TB] FAIL drop_first got=%0d/%h/%b exp=1/0/0", dropCntD, driveD, driveValidD);
        end
        valid = 4'b0010;
        #1;
        checks++; if (readyD !== 4'b0010) begin failures++; $display("[TB] FAIL drop_ready1 got=%b exp=0010", readyD); end
        step();
        checks++; if (dropCntD !== 4'd2 || eventCntD !== 4'd0 || driveD !== 32'h0 || driveValidD !== 1'b0) begin
            failures++; $display("[TB] FAIL drop_second got=%0d/%0d/%h/%b exp=2/0/0/0", dropCntD, eventCntD, driveD, driveValidD);
        end
        block = 1'b0;
        valid = 4'b0101;
        #1;
        checks++; if (readyD !== 4'b0100) begin failures++; $display("[TB] FAIL drop_next_ready got=%b exp=0100", readyD); end
        step();
        checks++; if (driveD !== 32'hC3 || grantIdD !== 2'd2 || eventCntD !== 4'd1 || dropCntD !== 4'd2) begin
            failures++; $display("[TB] FAIL drop_next got=%h/%0d/%0d/%0d exp=c3/2/1/2", driveD, grantIdD, eventCntD, dropCntD);
        end
        valid = 4'b0000;
    endtask

    task automatic test_saturation_clear();
        doReset();
        weight = {32'h0, 32'h0, 32'h0, 32'h77};
        valid = 4'b0001;
        repeat (20) step();
        checks++; if (eventCntS !== 4'd15) begin failures++; $display("[TB] FAIL sat_event got=%0d exp=15", eventCntS); end
        checks++; if (driveS !== 32'h77 || driveValidS !== 1'b1 || grantIdS !== 2'd0) begin
            failures++; $display("[TB] FAIL sat_back_to_back got=%h/%b/%0d exp=77/1/0", driveS, driveValidS, grantIdS);
        end
        block = 1'b1;
        repeat (20) step();
        checks++; if (dropCntD !== 4'd15) begin failures++; $display("[TB] FAIL sat_drop got=%0d exp=15", dropCntD); end
        block = 1'b0;
        clearCnt = 1'b1;
        step();
        checks++; if (eventCntS !== 4'd0 || dropCntD !== 4'd0 || eventCntD !== 4'd0) begin
            failures++; $display("[TB] FAIL clear_priority got=%0d/%0d/%0d exp=0/0/0", eventCntS, dropCntD, eventCntD);
        end
        checks++; if (driveValidS !== 1'b1 || driveS !== 32'h77) begin failures++; $display("[TB] FAIL clear_delivery got=%b/%h exp=1/77", driveValidS, driveS); end
        clearCnt = 1'b0;
        step();
        checks++; if (eventCntS !== 4'd1) begin failures++; $display("[TB] FAIL clear_resume got=%0d exp=1", eventCntS); end
        valid = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; valid = '0; weight = '0; block = 1'b0; clearCnt = 1'b0;
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_stall();
        test_drop();
        test_saturation_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_input_scheduler.md
Name: spike_input_scheduler

Overview:
- Round-robin scheduler that shares the single i_spike contribution input of a neuron among NUM_SRC presynaptic event sources.
- Accepts at most one weighted spike event per cycle via per-source valid/ready handshakes.
- Drives the neuron input register with the granted weight one cycle later.
- Honours a block input, driven from the neuron's output spike/refractory logic, by either stalling or dropping events. Keeps saturating event and drop statistics.

Parameters:
- DATA_LENGTH, 32: width of a weight word and of o_spike_drive.
- NUM_SRC, 4: number of requesting sources, 2..16.
- BLOCK_MODE, 0: behaviour while i_block=1. 0 = stall (no grants). 1 = drop (grant and discard).
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  NUM_SRC  per-source event request.
- i_weight  in  NUM_SRC*DATA_LENGTH  per-source weight; source k occupies bits [k*DATA_LENGTH +: DATA_LENGTH].
- o_ready  out  NUM_SRC  one-hot (or zero) grant, combinational.
- i_block  in  1  neuron blocking request (spike/refractory).
- i_clear_cnt  in  1  synchronous clear of the statistics counters.
- o_spike_drive  out  DATA_LENGTH  registered weight to the neuron i_spike.
- o_drive_valid  out  1  o_spike_drive carries a delivered event this cycle.
- o_grant_id  out  clog2(NUM_SRC)  source index of the current o_spike_drive.
- o_event_cnt  out  CNT_WIDTH  delivered events, saturating.
- o_drop_cnt  out  CNT_WIDTH  dropped events, saturating.

Behaviour:
- Reset is decided: i_rst is synchronous and active-high, sampled on i_clk. Reset values:
  - o_spike_drive = 0, o_drive_valid = 0, o_grant_id = 0
  - o_event_cnt = 0, o_drop_cnt = 0
  - round-robin pointer = 0
  - o_ready = 0 while i_rst = 1
- Reset mid-operation discards any in-flight event; no transfer is counted in the reset cycle.
- Transfer occurs for source k when i_valid[k] and o_ready[k] are both 1 at a rising edge.
- Sources hold i_valid and i_weight stable until transfer. i_valid must not depend on o_ready.
- Arbitration (combinational):
  - Search i_valid starting at the pointer index, wrapping modulo NUM_SRC.
  - The first set bit gets o_ready; all other bits are 0.
  - No valid bits gives o_ready = 0.
- Pointer update: after a transfer from source k, pointer = (k+1) mod NUM_SRC. Without a transfer, the pointer holds.
- Stall mode (BLOCK_MODE=0): i_block=1 forces o_ready=0. The pointer, counters and outputs behave as in an idle cycle.
- Drop mode (BLOCK_MODE=1): arbitration is unaffected by i_block. A transfer while i_block=1:
  - increments o_drop_cnt and advances the pointer;
  - leaves o_spike_drive = 0 and o_drive_valid = 0 next cycle.
- Delivered transfer (i_block=0):
  - next cycle o_spike_drive = weight, o_drive_valid = 1, o_grant_id = k;
  - o_event_cnt increments.
- Latency is exactly 1 cycle, handshake edge to o_spike_drive.
- A cycle without a delivered transfer sets o_spike_drive = 0 and o_drive_valid = 0; o_grant_id holds its last value. The neuron therefore receives zero contribution on idle cycles.
- Throughput: one event per cycle. Back-to-back grants to the same source are allowed only when no other source is valid.
- Counters:
  - saturate at 2^CNT_WIDTH-1 with no wrap;
  - i_clear_cnt=1 zeroes both counters next cycle, taking priority over a simultaneous increment;
  - i_rst has priority over i_clear_cnt.
- i_block changing in the same cycle as valid: the value of i_block sampled at that edge decides stall/drop versus delivery.
- No internal buffering. Weight values pass through unmodified, with no arithmetic on the weight.

Test Plan:
- Reset: hold i_rst 2 cycles with all i_valid=1 -> o_ready=0, o_spike_drive=0, both counters 0. After release the first grant goes to source 0.
- Round-robin fairness, NUM_SRC=4: all i_valid held high with weights 0x10,0x20,0x30,0x40 -> o_grant_id sequence 0,1,2,3,0. o_spike_drive follows the same order one cycle after each grant. o_event_cnt=5 after 5 grants.
- Pointer skip: only sources 1 and 3 valid after a grant to 1 -> next grant goes to 3, then 1. Idle cycles give o_spike_drive=0 and o_drive_valid=0.
- Stall, BLOCK_MODE=0: i_block=1 for 3 cycles with source 2 valid (weight 0x55) -> o_ready=0 for 3 cycles and counters unchanged. The cycle after i_block falls, o_spike_drive=0x55.
- Drop, BLOCK_MODE=1: i_block=1 while sources 0 and 1 present one event each -> both handshake, o_drop_cnt=2, o_event_cnt unchanged, o_spike_drive stays 0. The next grant goes to source 2 if valid.
- Saturation/clear, CNT_WIDTH=4: 20 delivered events -> o_event_cnt=15. Asserting i_clear_cnt in the same cycle as a grant -> counter reads 0 next cycle.
